// File: rtl/gate2_pkg.sv
// gate2_pkg: FSM state encoding, common truth tables and vector-index width for the gate checker
package gate2_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] TRUTH_AND = 4'b1000;
  localparam logic [3:0] TRUTH_OR  = 4'b1110;
  localparam logic [3:0] TRUTH_XOR = 4'b0110;
  localparam int VW = 2;
endpackage

// File: rtl/gate2_if.sv
// gate2_if: checker control/status bus plus the a,b,y pins of the gate under test
//   master: drives start and y (host + gate side), observes a,b and run status
//   slave : the checker, drives a,b,busy,done,pass,err_cnt,fail_vec
interface gate2_if #(parameter int ERRW = 4);
  logic start, y, a, b, busy, done, pass;
  logic [ERRW-1:0] err_cnt;
  logic [3:0] fail_vec;
  modport master (output start, y, input a, b, busy, done, pass, err_cnt, fail_vec);
  modport slave (input start, y, output a, b, busy, done, pass, err_cnt, fail_vec);
endinterface

// File: rtl/gate2_sync2.sv
// gate2_sync2: 2-flop synchronizer, async active-low reset to 0
//   clk, rst_n : clock, reset
//   d          : asynchronous input
//   q          : synchronized output
module gate2_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m_q} <= 2'b00;
    else {q, m_q} <= {m_q, d};
endmodule

// File: rtl/gate2_stim_checker.sv
// gate2_stim_checker: sweeps a 2-input gate through all input vectors and checks y against TRUTH
//   clk, rst_n : clock, async active-low reset
//   bus.start in; bus.y in (gate output); bus.a/b out (gate inputs = vec[1]/vec[0])
//   bus.busy, bus.done, bus.pass, bus.err_cnt, bus.fail_vec out (run status)
//   SYNC_Y_EN: route y through gate2_sync2 and stretch settle by 2 cycles
module gate2_stim_checker
  import gate2_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES = 1,
  parameter int ERRW = 4,
  parameter logic [3:0] TRUTH = TRUTH_AND
) (
  input logic clk,
  input logic rst_n,
  gate2_if.slave bus
);
`ifdef SYNC_Y_EN
  localparam int HOLD = SETTLE_CYC + 2;
  logic y_s;
  gate2_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(bus.y), .q(y_s));
`else
  localparam int HOLD = SETTLE_CYC;
  logic y_s;
  assign y_s = bus.y;
`endif
  localparam int CW = $clog2(HOLD + 1);
  localparam int PW = $clog2(PASSES + 1);
  state_t state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [3:0] fv_q, fv_d;
  logic busy_q, busy_d, pass_q, pass_d;
  logic miss, last;
  assign miss = y_s != TRUTH[vec_q];
  assign last = vec_q == 2'd3 && pidx_q == PW'(PASSES - 1);
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    pidx_d = pidx_q;
    err_d = err_q;
    fv_d = fv_q;
    busy_d = busy_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SETTLE;
        vec_d = '0;
        cnt_d = '0;
        pidx_d = '0;
        err_d = '0;
        fv_d = '0;
        pass_d = 1'b0;
        busy_d = 1'b1;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(HOLD - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        // the final sample's mismatch must land in err_cnt/fail_vec/pass at the same edge as DONE
        if (miss) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          fv_d[vec_q] = 1'b1;
        end
        if (last) begin
          state_d = DONE;
          busy_d = 1'b0;
          pass_d = err_q == '0 && !miss;
        end else begin
          state_d = SETTLE;
          vec_d = vec_q + 1'b1;
          cnt_d = '0;
          pidx_d = vec_q == 2'd3 ? pidx_q + 1'b1 : pidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      cnt_q <= '0;
      pidx_q <= '0;
      err_q <= '0;
      fv_q <= '0;
      busy_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      pidx_q <= pidx_d;
      err_q <= err_d;
      fv_q <= fv_d;
      busy_q <= busy_d;
      pass_q <= pass_d;
    end
  assign bus.a = vec_q[1];
  assign bus.b = vec_q[0];
  assign bus.busy = busy_q;
  assign bus.done = state_q == DONE;
  assign bus.pass = pass_q;
  assign bus.err_cnt = err_q;
  assign bus.fail_vec = fv_q;
endmodule

// File: tb/tb_gate2_stim_checker.sv
// tb_gate2_stim_checker: table-driven runs on three checker configurations with a done-time scoreboard
module tb_gate2_stim_checker;
  import gate2_pkg::*;
`ifdef SYNC_Y_EN
  localparam int EX = 2;
`else
  localparam int EX = 0;
`endif
  typedef struct {int id; logic p; int e; logic [3:0] f; int dc;} exp_t;
  typedef struct {int id; int ym; logic p; int e; logic [3:0] f;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ym[3] = '{0, 0, 0};
  int dones[3] = '{0, 0, 0};
  exp_t sb[$];
  vec_t tv[7];
  gate2_if #(.ERRW(4)) if0 ();
  gate2_if #(.ERRW(2)) if1 ();
  gate2_if #(.ERRW(4)) if2 ();
  // gate models: 0 = ideal AND, 1 = y stuck at 1, 2 = y stuck at 0
  assign if0.y = (ym[0] == 0) ? (if0.a & if0.b) : (ym[0] == 1);
  assign if1.y = (ym[1] == 0) ? (if1.a & if1.b) : (ym[1] == 1);
  assign if2.y = (ym[2] == 0) ? (if2.a & if2.b) : (ym[2] == 1);
  gate2_stim_checker d0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate2_stim_checker #(.PASSES(5), .ERRW(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  gate2_stim_checker #(.SETTLE_CYC(1)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic int lat(input int id);
    return id == 1 ? 20 * (3 + EX) : id == 2 ? 4 * (2 + EX) : 4 * (3 + EX);
  endfunction
  task automatic score(input int id, input logic p, input int e, input logic [3:0] f);
    exp_t x;
    dones[id]++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: dut%0d at cycle %0d, expected none", id, cyc);
      return;
    end
    x = sb.pop_front();
    chk("done_dut", id, x.id);
    chk("pass", int'(p), int'(x.p));
    chk("err_cnt", e, x.e);
    chk("fail_vec", int'(f), int'(x.f));
    chk("done_cycle", cyc, x.dc);
  endtask
  always @(negedge clk) begin
    if (if0.done) score(0, if0.pass, int'(if0.err_cnt), if0.fail_vec);
    if (if1.done) score(1, if1.pass, int'(if1.err_cnt), if1.fail_vec);
    if (if2.done) score(2, if2.pass, int'(if2.err_cnt), if2.fail_vec);
  end
  task automatic set_start(input int id, input logic v);
    if0.start = v && id == 0;
    if1.start = v && id == 1;
    if2.start = v && id == 2;
  endtask
  task automatic push(input int id, input logic p, input int e, input logic [3:0] f, input int dc);
    exp_t x;
    x.id = id; x.p = p; x.e = e; x.f = f; x.dc = dc;
    sb.push_back(x);
  endtask
  task automatic launch(input int id, input int m, input logic p, input int e, input logic [3:0] f);
    ym[id] = m;
    @(negedge clk);
    push(id, p, e, f, cyc + 1 + lat(id));
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
  endtask
  task automatic drain(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    int c, d;
    tv[0] = '{0, 0, 1'b1, 0, 4'b0000};
    tv[1] = '{0, 1, 1'b0, 3, 4'b0111};
    tv[2] = '{0, 2, 1'b0, 1, 4'b1000};
    tv[3] = '{1, 2, 1'b0, 3, 4'b1000};
    tv[4] = '{1, 0, 1'b1, 0, 4'b0000};
    tv[5] = '{2, 0, 1'b1, 0, 4'b0000};
    tv[6] = '{2, 1, 1'b0, 3, 4'b0111};
    set_start(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_a", int'(if0.a), 0);
    chk("rst_b", int'(if0.b), 0);
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_pass", int'(if0.pass), 0);
    chk("rst_err", int'(if0.err_cnt), 0);
    chk("rst_fv", int'(if0.fail_vec), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      launch(tv[i].id, tv[i].ym, tv[i].p, tv[i].e, tv[i].f);
      drain(300);
    end
    // a,b walk 00,01,10,11, each held for a full vector period while busy
    ym[0] = 0;
    @(negedge clk);
    c = cyc;
    push(0, 1'b1, 0, 4'b0000, c + 1 + lat(0));
    set_start(0, 1'b1);
    for (int k = 0; k < lat(0); k++) begin
      @(negedge clk);
      set_start(0, 1'b0);
      chk("ab_seq", int'({if0.a, if0.b}), k / (3 + EX));
      chk("busy_run", int'(if0.busy), 1);
    end
    drain(50);
    // start pulses while busy and during DONE must be ignored
    d = dones[0];
    launch(0, 0, 1'b1, 0, 4'b0000);
    repeat (3) @(negedge clk);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    for (int i = 0; i < 100 && !if0.done; i++) @(negedge clk);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (30) @(negedge clk);
    chk("ignored_starts_done_count", dones[0] - d, 1);
    drain(10);
    // start held high: second run accepted on the IDLE cycle following DONE
    @(negedge clk);
    c = cyc;
    push(0, 1'b1, 0, 4'b0000, c + 1 + lat(0));
    push(0, 1'b1, 0, 4'b0000, c + 3 + 2 * lat(0));
    set_start(0, 1'b1);
    repeat (lat(0) + 4) @(negedge clk);
    set_start(0, 1'b0);
    drain(100);
    // reset at cycle 5 of a run aborts it with no done
    d = dones[0];
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", int'(if0.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_a", int'(if0.a), 0);
    chk("abort_b", int'(if0.b), 0);
    chk("abort_busy", int'(if0.busy), 0);
    chk("abort_done", int'(if0.done), 0);
    chk("abort_err", int'(if0.err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", dones[0] - d, 0);
    launch(0, 0, 1'b1, 0, 4'b0000);
    drain(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
